bht_update_pipe: RTL and testbench
==================================

// Module: bht_update_pipe
// PURPOSE
//  Branch history table (BHT) of 2-bit saturating counters for conditional branches.
//  Downstream consumer of the branch unit's resolved_branch output; trains on resolved conditional branches.
//  Upstream of frontend PC generation: serves a taken/not-taken prediction for the current fetch vpc.
//  Contains a registered update stage with read bypass, and a multi-cycle flush walker.
// PARAMETERS
//  NR_ENTRIES  64  table depth; power of two, >=2 (elaboration assertion)
//  OFFSET      1   pc bits dropped before indexing (1 = compressed-instruction granularity)
// PORTS
//  clk_i              in   1     clock
//  rst_i              in   1     reset, asynchronous, active-high
//  flush_i            in   1     start table flush walk
//  debug_mode_i       in   1     1 = drop all training updates
//  vpc_i              in   64    fetch address to predict
//  bht_valid_o        out  1     indexed entry holds trained state
//  bht_taken_o        out  1     predicted direction (counter MSB)
//  flush_busy_o       out  1     flush walk in progress
//  resolved_branch_i  in   ariane_pkg::branchpredict_t  resolved branch from branch unit
//  perf_updates_o     out  32    training-update count (see CONFIGURATION)
//  perf_mispredict_o  out  32    mispredict count (see CONFIGURATION)
// BEHAVIOUR
//  - Index: pc[$clog2(NR_ENTRIES)+OFFSET-1:OFFSET]. Entry = {valid, cnt[1:0]}.
//  - Reset:
//    - all entries 0; FSM IDLE; walk index 0; pending-update register invalid.
//    - Outputs 0, except perf counters (see CONFIGURATION).
//  - Train qualify, cycle N:
//    - resolved_branch_i.valid & cf_type==ariane_pkg::Branch & !debug_mode_i & FSM==IDLE & !flush_i.
//    - Qualified update is captured into the pending register {valid, index, taken}.
//    - All other control-flow types are ignored.
//  - Apply, end of cycle N+1: pending entry is written to the table.
//    - Invalid entry -> valid=1, cnt = taken ? 2'b10 : 2'b01.
//    - Valid entry -> cnt+1 if taken (saturate 11), cnt-1 if not taken (saturate 00).
//    - Back-to-back updates to the same index use the pending (not table) value as the base.
//      Two consecutive taken updates from 01 therefore yield 11.
//  - Lookup: combinational from vpc_i.
//    - bht_valid_o = entry.valid & FSM==IDLE; bht_taken_o = cnt[1] & bht_valid_o.
//    - Bypass: if pending valid and index matches, output the post-update value.
//    - Update is visible to lookup from cycle N+1 onward.
//  - FSM IDLE -> FLUSH on flush_i:
//    - Walk index=0; pending register invalidated (pending update lost).
//  - FSM FLUSH:
//    - Each cycle clears entry[walk], walk++.
//    - At walk==NR_ENTRIES-1: clear, walk->0, return to IDLE. Duration exactly NR_ENTRIES cycles.
//    - flush_busy_o=1 throughout; predictions invalid; training updates dropped.
//    - flush_i while in FLUSH restarts walk at 0.
//  - Simultaneous flush_i and qualified update in IDLE: flush wins, update dropped.
//  - Async reset mid-flush: immediate IDLE with cleared table; no partial state survives.
// CONFIGURATION
//  BHT_PERF_CNT_EN defined:
//    - perf_updates_o increments on each qualified train.
//    - perf_mispredict_o increments on each qualified train with is_mispredict=1.
//    - Both 32-bit, saturating at 32'hFFFF_FFFF, cleared by rst_i only (not flush).
//  BHT_PERF_CNT_EN undefined: both ports tied to 32'h0, no counter flops.
// TESTING
//  - Reset, vpc_i=0x1000 -> bht_valid_o=0, bht_taken_o=0, flush_busy_o=0.
//  - Train taken pc=0x1000 at cycle 0 -> cycle 1 lookup 0x1000: valid=1, taken=1 (bypass); cycle 2 via table: same.
//  - Training sequences on pc=0x1000:
//    - 3x taken then 1x not-taken -> cnt 10->11->11->10, taken stays 1.
//    - Then 2x not-taken -> cnt 00, taken=0.
//  - Train with cf_type=JumpR or debug_mode_i=1 -> entry unchanged, perf_updates_o unchanged.
//  - Flush, NR_ENTRIES=64:
//    - flush_i pulse -> flush_busy_o high for exactly 64 cycles; all lookups invalid afterwards.
//    - Update issued during walk is dropped.
//    - flush_i re-asserted at cycle 10 -> busy for 64 more cycles.
//  - BHT_PERF_CNT_EN:
//    - 5 trains with 2 mispredicts -> perf_updates_o=5, perf_mispredict_o=2; unchanged by flush.
//    - Reset -> both 0.

Source files
------------

// File: rtl/bht_update_pipe.sv
// Branch history table of 2-bit saturating counters with a registered training stage,
// read bypass and a multi-cycle flush walker. Optional perf counters: BHT_PERF_CNT_EN.
package ariane_pkg;
    typedef enum logic [2:0] {NoCF, Branch, Jump, JumpR, Return} cf_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] target_address;
        logic        is_mispredict;
        logic        is_taken;
        cf_t         cf_type;
    } branchpredict_t;
endpackage

module bht_update_pipe #(
    parameter int unsigned NR_ENTRIES = 64,
    parameter int unsigned OFFSET     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       debug_mode_i,
    input  logic [63:0]                vpc_i,
    output logic                       bht_valid_o,
    output logic                       bht_taken_o,
    output logic                       flush_busy_o,
    input  ariane_pkg::branchpredict_t resolved_branch_i,
    output logic [31:0]                perf_updates_o,
    output logic [31:0]                perf_mispredict_o
);
    localparam int unsigned IDX_W = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;

    if ((NR_ENTRIES < 2) || ((NR_ENTRIES & (NR_ENTRIES - 1)) != 0)) begin : g_bad_depth
        $error("NR_ENTRIES must be a power of two >= 2");
    end

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] walk_q, walk_d;
    logic             clr_en;

    logic             valid_q [NR_ENTRIES];
    logic [1:0]       cnt_q   [NR_ENTRIES];

    logic             pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0] pend_idx_q, pend_idx_d;
    logic             pend_taken_q, pend_taken_d;

    logic             qualify;
    logic             wr_en;
    logic [2:0]       pend_entry;
    logic [IDX_W-1:0] look_idx;
    logic [2:0]       look_entry;

    // Entry is {valid, cnt}; an untrained entry is seeded weakly in the trained direction.
    function automatic logic [2:0] train(input logic [2:0] e, input logic taken);
        if (!e[2])
            return {1'b1, (taken ? 2'b10 : 2'b01)};
        if (taken)
            return {1'b1, ((e[1:0] == 2'b11) ? 2'b11 : e[1:0] + 2'b01)};
        return {1'b1, ((e[1:0] == 2'b00) ? 2'b00 : e[1:0] - 2'b01)};
    endfunction

    assign qualify = resolved_branch_i.valid
                   && (resolved_branch_i.cf_type == ariane_pkg::Branch)
                   && !debug_mode_i && (state_q == IDLE) && !flush_i;

    // Pending is only ever valid in IDLE; a flush arriving with it discards it.
    assign wr_en      = pend_vld_q && !flush_i;
    assign pend_entry = train({valid_q[pend_idx_q], cnt_q[pend_idx_q]}, pend_taken_q);

    assign pend_vld_d   = qualify;
    assign pend_idx_d   = resolved_branch_i.pc[IDX_W+OFFSET-1:OFFSET];
    assign pend_taken_d = resolved_branch_i.is_taken;

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    walk_d  = '0;
                end
            end
            FLUSH: begin
                clr_en = 1'b1;
                if (flush_i) begin
                    walk_d = '0;
                end else if (walk_q == IDX_W'(NR_ENTRIES - 1)) begin
                    walk_d  = '0;
                    state_d = IDLE;
                end else begin
                    walk_d = walk_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            walk_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            walk_q     <= walk_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        pend_idx_q   <= pend_idx_d;
        pend_taken_q <= pend_taken_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'b00;
            end
        end else if (clr_en) begin
            valid_q[walk_q] <= 1'b0;
            cnt_q[walk_q]   <= 2'b00;
        end else if (wr_en) begin
            valid_q[pend_idx_q] <= pend_entry[2];
            cnt_q[pend_idx_q]   <= pend_entry[1:0];
        end
    end

    // Lookup bypasses the entry about to be written so training is visible one cycle early.
    assign look_idx   = vpc_i[IDX_W+OFFSET-1:OFFSET];
    assign look_entry = (wr_en && (pend_idx_q == look_idx)) ? pend_entry
                                                            : {valid_q[look_idx], cnt_q[look_idx]};

    assign bht_valid_o  = look_entry[2] && (state_q == IDLE);
    assign bht_taken_o  = look_entry[1] && bht_valid_o;
    assign flush_busy_o = (state_q == FLUSH);

`ifdef BHT_PERF_CNT_EN
    logic [31:0] perf_upd_q, perf_upd_d;
    logic [31:0] perf_mis_q, perf_mis_d;

    always_comb begin
        perf_upd_d = perf_upd_q;
        perf_mis_d = perf_mis_q;
        if (qualify && (perf_upd_q != 32'hFFFF_FFFF))
            perf_upd_d = perf_upd_q + 32'd1;
        if (qualify && resolved_branch_i.is_mispredict && (perf_mis_q != 32'hFFFF_FFFF))
            perf_mis_d = perf_mis_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_updates_o    = perf_upd_q;
    assign perf_mispredict_o = perf_mis_q;
`else
    assign perf_updates_o    = 32'h0;
    assign perf_mispredict_o = 32'h0;
`endif

    logic unused_bits;
    assign unused_bits = ^{resolved_branch_i.target_address, resolved_branch_i.is_mispredict,
                           resolved_branch_i.pc, vpc_i};

endmodule

// File: tb/tb_bht_update_pipe.sv
// Directed bench for bht_update_pipe: table-driven training vectors plus flush/reset sequences.
module tb_bht_update_pipe;
    logic                       clk = 1'b0;
    logic                       rst_i;
    logic                       flush_i;
    logic                       debug_mode_i;
    logic [63:0]                vpc_i;
    logic                       bht_valid_o;
    logic                       bht_taken_o;
    logic                       flush_busy_o;
    ariane_pkg::branchpredict_t rb;
    logic [31:0]                perf_updates_o;
    logic [31:0]                perf_mispredict_o;

    int n_pass  = 0;
    int n_total = 0;

`ifdef BHT_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    bht_update_pipe #(.NR_ENTRIES(64), .OFFSET(1)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .debug_mode_i      (debug_mode_i),
        .vpc_i             (vpc_i),
        .bht_valid_o       (bht_valid_o),
        .bht_taken_o       (bht_taken_o),
        .flush_busy_o      (flush_busy_o),
        .resolved_branch_i (rb),
        .perf_updates_o    (perf_updates_o),
        .perf_mispredict_o (perf_mispredict_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        ariane_pkg::cf_t cf;
        logic            taken;
        logic            misp;
        logic            dbg;
        logic            exp_v;
        logic            exp_t;
        int              exp_upd;
        int              exp_mis;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_train(input logic [63:0] pc, input ariane_pkg::cf_t cf,
                               input logic taken, input logic misp);
        rb               = '0;
        rb.valid         = 1'b1;
        rb.pc            = pc;
        rb.cf_type       = cf;
        rb.is_taken      = taken;
        rb.is_mispredict = misp;
    endtask

    // Counts busy cycles until the walker returns to IDLE, bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200 && flush_busy_o; i++) begin
            n++;
            step();
        end
    endtask

    initial begin
        int busy_n;
        int upd_base;

        vecs[0] = '{ariane_pkg::Branch, 1, 0, 0, 1, 1, 1, 0};
        vecs[1] = '{ariane_pkg::Branch, 1, 0, 0, 1, 1, 2, 0};
        vecs[2] = '{ariane_pkg::Branch, 1, 0, 0, 1, 1, 3, 0};
        vecs[3] = '{ariane_pkg::Branch, 0, 1, 0, 1, 1, 4, 1};
        vecs[4] = '{ariane_pkg::Branch, 0, 1, 0, 1, 0, 5, 2};
        vecs[5] = '{ariane_pkg::Branch, 0, 0, 0, 1, 0, 6, 2};
        vecs[6] = '{ariane_pkg::JumpR,  1, 1, 0, 1, 0, 6, 2};
        vecs[7] = '{ariane_pkg::Branch, 1, 1, 1, 1, 0, 6, 2};
        vecs[8] = '{ariane_pkg::Branch, 1, 0, 0, 1, 0, 7, 2};
        vecs[9] = '{ariane_pkg::Branch, 1, 0, 0, 1, 1, 8, 2};

        rst_i        = 1'b1;
        flush_i      = 1'b0;
        debug_mode_i = 1'b0;
        vpc_i        = 64'h1000;
        rb           = '0;
        step();
        step();
        check("reset_valid", 32'(bht_valid_o), 32'd0);
        check("reset_taken", 32'(bht_taken_o), 32'd0);
        check("reset_busy", 32'(flush_busy_o), 32'd0);
        check("reset_perf_upd", perf_updates_o, 32'd0);
        check("reset_perf_mis", perf_mispredict_o, 32'd0);
        rst_i = 1'b0;
        step();

        // Back-to-back training on pc 0x1000; each result seen via bypass the next cycle.
        for (int i = 0; i < 10; i++) begin
            drive_train(64'h1000, vecs[i].cf, vecs[i].taken, vecs[i].misp);
            debug_mode_i = vecs[i].dbg;
            step();
            rb           = '0;
            debug_mode_i = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(bht_valid_o), 32'(vecs[i].exp_v));
            check($sformatf("vec%0d_taken", i), 32'(bht_taken_o), 32'(vecs[i].exp_t));
            check($sformatf("vec%0d_perf_upd", i), perf_updates_o, PERF ? 32'(vecs[i].exp_upd) : 32'd0);
            check($sformatf("vec%0d_perf_mis", i), perf_mispredict_o, PERF ? 32'(vecs[i].exp_mis) : 32'd0);
        end
        step();
        check("table_valid", 32'(bht_valid_o), 32'd1);
        check("table_taken", 32'(bht_taken_o), 32'd1);
        vpc_i = 64'h1002;
        #1;
        check("neighbour_valid", 32'(bht_valid_o), 32'd0);

        // Flush with a simultaneous qualified update: the update must be dropped.
        upd_base = PERF ? 8 : 0;
        vpc_i    = 64'h1000;
        drive_train(64'h1002, ariane_pkg::Branch, 1'b1, 1'b1);
        flush_i = 1'b1;
        step();
        rb      = '0;
        flush_i = 1'b0;
        check("flush_busy_first", 32'(flush_busy_o), 32'd1);
        check("flush_lookup_invalid", 32'(bht_valid_o), 32'd0);
        busy_n = 0;
        for (int i = 0; i < 200 && flush_busy_o; i++) begin
            busy_n++;
            if (busy_n == 5) drive_train(64'h1002, ariane_pkg::Branch, 1'b1, 1'b0);
            step();
            rb = '0;
        end
        check("flush_busy_cycles", 32'(busy_n), 32'd64);
        #1;
        check("post_flush_1000_valid", 32'(bht_valid_o), 32'd0);
        vpc_i = 64'h1002;
        #1;
        check("post_flush_1002_valid", 32'(bht_valid_o), 32'd0);
        check("flush_perf_upd", perf_updates_o, 32'(upd_base));

        // Re-assert flush mid-walk: the walk restarts and runs a full 64 more cycles.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("reflush_busy_mid", 32'(flush_busy_o), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        count_busy(busy_n);
        check("reflush_busy_cycles", 32'(busy_n), 32'd64);

        // Asynchronous reset during a walk: immediate IDLE, table cleared.
        vpc_i = 64'h50;
        drive_train(64'h50, ariane_pkg::Branch, 1'b1, 1'b0);
        step();
        rb = '0;
        step();
        check("idx40_trained", 32'(bht_valid_o), 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_busy", 32'(flush_busy_o), 32'd0);
        check("async_rst_idx40", 32'(bht_valid_o), 32'd0);
        check("async_rst_perf_upd", perf_updates_o, 32'd0);
        step();
        rst_i = 1'b0;
        step();
        check("after_rst_idx40", 32'(bht_valid_o), 32'd0);

        // Five trains, two mispredicts; counters must survive a flush.
        vpc_i = 64'h1000;
        drive_train(64'h1000, ariane_pkg::Branch, 1'b1, 1'b1); step();
        drive_train(64'h1000, ariane_pkg::Branch, 1'b0, 1'b0); step();
        drive_train(64'h1004, ariane_pkg::Branch, 1'b1, 1'b1); step();
        drive_train(64'h1000, ariane_pkg::Branch, 1'b0, 1'b0); step();
        drive_train(64'h1006, ariane_pkg::Branch, 1'b1, 1'b0); step();
        rb = '0;
        step();
        check("perf5_upd", perf_updates_o, PERF ? 32'd5 : 32'd0);
        check("perf5_mis", perf_mispredict_o, PERF ? 32'd2 : 32'd0);
        check("perf5_lookup_valid", 32'(bht_valid_o), 32'd1);
        check("perf5_lookup_taken", 32'(bht_taken_o), 32'd0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        count_busy(busy_n);
        check("perf5_flush_busy", 32'(busy_n), 32'd64);
        check("perf5_upd_after_flush", perf_updates_o, PERF ? 32'd5 : 32'd0);
        check("perf5_mis_after_flush", perf_mispredict_o, PERF ? 32'd2 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
